// File: rtl/vga_timing_gen_pkg.sv
// Shared 640x480@60 VGA timing constants and helper types.
// The timing generator and the colour driver both use this package.
package vga_timing_gen_pkg;

    localparam int CLK_DIV   = 4;

    localparam int H_VISIBLE = 640;
    localparam int H_FRONT   = 16;
    localparam int H_SYNC    = 96;
    localparam int H_BACK    = 48;
    localparam int H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int H_SYNC_START = H_VISIBLE + H_FRONT;
    localparam int H_SYNC_END   = H_SYNC_START + H_SYNC - 1;

    localparam int V_VISIBLE = 480;
    localparam int V_FRONT   = 10;
    localparam int V_SYNC    = 2;
    localparam int V_BACK    = 33;
    localparam int V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int V_SYNC_START = V_VISIBLE + V_FRONT;
    localparam int V_SYNC_END   = V_SYNC_START + V_SYNC - 1;

    localparam int CELL_W    = 80;
    localparam int CELL_H    = 60;
    localparam int GRID_COLS = H_VISIBLE / CELL_W;
    localparam int GRID_ROWS = V_VISIBLE / CELL_H;

    localparam logic SYNC_POL = 1'b0;

    localparam int CNT_W      = 10;
    localparam int CELL_IDX_W = 4;
    localparam int SUB_W      = 7;

    typedef logic [CNT_W-1:0]      coord_t;
    typedef logic [CELL_IDX_W-1:0] cell_idx_t;
    typedef logic [SUB_W-1:0]      sub_cnt_t;

    // Inclusive range test used for the sync windows.
    function automatic logic in_range(input coord_t value, input coord_t lo, input coord_t hi);
        return (value >= lo) && (value <= hi);
    endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Bundle of timing outputs handed from the generator to the colour driver and cell lookup.
interface vga_timing_gen_if;
    import vga_timing_gen_pkg::*;

    coord_t    current_row;
    coord_t    current_line;
    logic      enable;
    logic      hsync;
    logic      vsync;
    cell_idx_t cell_x;
    cell_idx_t cell_y;
    logic      pix_tick;
    logic      frame_start;

    modport master (
        output current_row, current_line, enable, hsync, vsync,
               cell_x, cell_y, pix_tick, frame_start
    );

    modport slave (
        input  current_row, current_line, enable, hsync, vsync,
               cell_x, cell_y, pix_tick, frame_start
    );

endinterface

// File: rtl/vga_timing_gen_axis_counter.sv
// One VGA axis: wrapping position counter with registered position/sync outputs and a
// cell index tracked by a sub-counter, so no divider is needed.
module vga_timing_gen_axis_counter
    import vga_timing_gen_pkg::*;
#(
    parameter int   TOTAL      = H_TOTAL,
    parameter int   VISIBLE    = H_VISIBLE,
    parameter int   SYNC_START = H_SYNC_START,
    parameter int   SYNC_END   = H_SYNC_END,
    parameter int   CELL       = CELL_W,
    parameter int   CELLS      = GRID_COLS,
    parameter logic POL        = SYNC_POL
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      advance,
    output logic      wrap,
    output logic      visible_next,
    output coord_t    count,
    output logic      sync,
    output cell_idx_t cell_idx
);

    localparam coord_t    POS_LAST   = coord_t'(TOTAL - 1);
    localparam coord_t    VIS_LAST   = coord_t'(VISIBLE - 1);
    localparam coord_t    VIS_COUNT  = coord_t'(VISIBLE);
    localparam coord_t    SYNC_FIRST = coord_t'(SYNC_START);
    localparam coord_t    SYNC_LAST  = coord_t'(SYNC_END);
    localparam sub_cnt_t  SUB_LAST   = sub_cnt_t'(CELL - 1);
    localparam cell_idx_t CELL_LAST  = cell_idx_t'(CELLS - 1);

    coord_t    pos_q, pos_d;
    coord_t    count_q, count_d;
    sub_cnt_t  sub_q, sub_d;
    cell_idx_t cell_q, cell_d;
    logic      sync_q, sync_d;

    // Cell index only moves while the position stays inside the visible span, so it
    // parks on the last column/row through blanking and restarts with the wrap.
    always_comb begin
        wrap    = advance && (pos_q == POS_LAST);
        pos_d   = pos_q;
        sub_d   = sub_q;
        cell_d  = cell_q;
        count_d = count_q;
        sync_d  = sync_q;
        if (advance) begin
            pos_d = wrap ? '0 : pos_q + 1'b1;
            if (wrap) begin
                sub_d  = '0;
                cell_d = '0;
            end else if (pos_q < VIS_LAST) begin
                if (sub_q == SUB_LAST) begin
                    sub_d = '0;
                    if (cell_q != CELL_LAST) begin
                        cell_d = cell_q + 1'b1;
                    end
                end else begin
                    sub_d = sub_q + 1'b1;
                end
            end
            count_d = pos_d;
            sync_d  = in_range(pos_d, SYNC_FIRST, SYNC_LAST) ? POL : ~POL;
        end
        visible_next = (pos_d < VIS_COUNT);
    end

    // The hidden position starts on the last count so the first advance lands on 0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pos_q   <= POS_LAST;
            sub_q   <= '0;
            cell_q  <= '0;
            count_q <= '0;
            sync_q  <= ~POL;
        end else begin
            pos_q   <= pos_d;
            sub_q   <= sub_d;
            cell_q  <= cell_d;
            count_q <= count_d;
            sync_q  <= sync_d;
        end
    end

    assign count    = count_q;
    assign sync     = sync_q;
    assign cell_idx = cell_q;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA timing generator: pixel-tick divider feeding horizontal and vertical axis counters.
// All outputs are registered on the tick edge so the whole set changes together.
module vga_timing_gen #(
    parameter int   CLK_DIV   = vga_timing_gen_pkg::CLK_DIV,
    parameter int   H_VISIBLE = vga_timing_gen_pkg::H_VISIBLE,
    parameter int   H_FRONT   = vga_timing_gen_pkg::H_FRONT,
    parameter int   H_SYNC    = vga_timing_gen_pkg::H_SYNC,
    parameter int   H_BACK    = vga_timing_gen_pkg::H_BACK,
    parameter int   V_VISIBLE = vga_timing_gen_pkg::V_VISIBLE,
    parameter int   V_FRONT   = vga_timing_gen_pkg::V_FRONT,
    parameter int   V_SYNC    = vga_timing_gen_pkg::V_SYNC,
    parameter int   V_BACK    = vga_timing_gen_pkg::V_BACK,
    parameter int   CELL_W    = vga_timing_gen_pkg::CELL_W,
    parameter int   CELL_H    = vga_timing_gen_pkg::CELL_H,
    parameter logic SYNC_POL  = vga_timing_gen_pkg::SYNC_POL
) (
    input  logic             clk_in,
    input  logic             rst_n,
    vga_timing_gen_if.master vga
);

    localparam int H_TOTAL      = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL      = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int H_SYNC_START = H_VISIBLE + H_FRONT;
    localparam int V_SYNC_START = V_VISIBLE + V_FRONT;
    localparam int DIV_W        = $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic             tick;

    logic h_wrap, h_visible_next, h_sync;
    logic v_wrap, v_visible_next, v_sync;
    vga_timing_gen_pkg::coord_t    h_count, v_count;
    vga_timing_gen_pkg::cell_idx_t cell_x, cell_y;

    logic enable_q, enable_d;
    logic pix_tick_q, pix_tick_d;
    logic frame_start_q, frame_start_d;

    always_comb begin
        tick      = (div_cnt_q == DIV_LAST);
        div_cnt_d = tick ? '0 : div_cnt_q + 1'b1;
    end

    vga_timing_gen_axis_counter #(
        .TOTAL      (H_TOTAL),
        .VISIBLE    (H_VISIBLE),
        .SYNC_START (H_SYNC_START),
        .SYNC_END   (H_SYNC_START + H_SYNC - 1),
        .CELL       (CELL_W),
        .CELLS      (H_VISIBLE / CELL_W),
        .POL        (SYNC_POL)
    ) u_h_axis (
        .clk          (clk_in),
        .rst_n        (rst_n),
        .advance      (tick),
        .wrap         (h_wrap),
        .visible_next (h_visible_next),
        .count        (h_count),
        .sync         (h_sync),
        .cell_idx     (cell_x)
    );

    // The vertical axis steps once per line, on the tick that wraps the horizontal axis.
    vga_timing_gen_axis_counter #(
        .TOTAL      (V_TOTAL),
        .VISIBLE    (V_VISIBLE),
        .SYNC_START (V_SYNC_START),
        .SYNC_END   (V_SYNC_START + V_SYNC - 1),
        .CELL       (CELL_H),
        .CELLS      (V_VISIBLE / CELL_H),
        .POL        (SYNC_POL)
    ) u_v_axis (
        .clk          (clk_in),
        .rst_n        (rst_n),
        .advance      (h_wrap),
        .wrap         (v_wrap),
        .visible_next (v_visible_next),
        .count        (v_count),
        .sync         (v_sync),
        .cell_idx     (cell_y)
    );

    always_comb begin
        enable_d      = tick ? (h_visible_next & v_visible_next) : enable_q;
        pix_tick_d    = tick;
        frame_start_d = v_wrap;
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            div_cnt_q     <= '0;
            enable_q      <= 1'b0;
            pix_tick_q    <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            div_cnt_q     <= div_cnt_d;
            enable_q      <= enable_d;
            pix_tick_q    <= pix_tick_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign vga.current_row  = h_count;
    assign vga.current_line = v_count;
    assign vga.enable       = enable_q;
    assign vga.hsync        = h_sync;
    assign vga.vsync        = v_sync;
    assign vga.cell_x       = cell_x;
    assign vga.cell_y       = cell_y;
    assign vga.pix_tick     = pix_tick_q;
    assign vga.frame_start  = frame_start_q;

endmodule
